// File: rtl/data_mem_access_unit.sv
// data_mem_access_unit
//   Initiator side of the word-addressed data-memory port. Accepts byte-addressed
//   byte/halfword/word load/store requests from the core over valid/ready, drives
//   the memory with registered enables/address/data, and returns one response pulse
//   per request. Sub-word stores use a read-modify-write.
//   Misaligned, out-of-range or illegal-size requests complete with an error and
//   never touch memory.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake (ready only while idle)
//   req_write, req_size,       store/load, 00 byte 01 half 10 word,
//   req_unsigned, req_addr,    zero/sign extend for loads, byte address,
//   req_wdata                  right-justified store data
//   rsp_valid, rsp_rdata,      one-cycle completion pulse, extended load data,
//   rsp_error                  error flag
//   address, MemRead,          memory side: word index and read enable,
//   writeData, MemWrite        write word and write enable
//   readData                   combinational memory read data
module data_mem_access_unit #(
    parameter int DEPTH       = 10,
    parameter bit RANGE_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] address,
    output logic        MemRead,
    output logic [31:0] writeData,
    output logic        MemWrite,
    input  logic [31:0] readData
);

    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_STORE, S_RMW_RD, S_RMW_WR, S_ERR, S_RESP
    } state_t;

    state_t      state_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic [31:0] address_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [31:0] write_data_q;
    logic        rsp_valid_q;
    logic        rsp_error_q;
    logic [31:0] rsp_rdata_q;

    logic        req_err_d;
    logic [7:0]  byte_d;
    logic [15:0] half_d;
    logic [31:0] load_ext_d;
    logic [4:0]  shamt_d;
    logic [31:0] mask_d;
    logic [31:0] merge_d;

    // Request classification, evaluated on the live request in IDLE.
    always_comb begin
        req_err_d = 1'b0;
        if (req_size == 2'b11)                                req_err_d = 1'b1;
        if (req_size == 2'b01 && req_addr[0])                 req_err_d = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00)      req_err_d = 1'b1;
        if (RANGE_CHECK && (req_addr[31:2] >= DEPTH_W))       req_err_d = 1'b1;
    end

    // Lane extraction / extension and sub-word merge, both from captured fields.
    always_comb begin
        byte_d     = 8'(readData >> {lane_q, 3'b000});
        half_d     = lane_q[1] ? readData[31:16] : readData[15:0];
        load_ext_d = readData;
        case (size_q)
            2'b00:   load_ext_d = unsigned_q ? {24'h0, byte_d} : {{24{byte_d[7]}}, byte_d};
            2'b01:   load_ext_d = unsigned_q ? {16'h0, half_d} : {{16{half_d[15]}}, half_d};
            default: load_ext_d = readData;
        endcase

        if (size_q == 2'b00) begin
            shamt_d = {lane_q, 3'b000};
            mask_d  = 32'h0000_00FF << shamt_d;
        end else begin
            shamt_d = {lane_q[1], 4'b0000};
            mask_d  = 32'h0000_FFFF << shamt_d;
        end
        merge_d = (readData & ~mask_d) | ((wdata_q << shamt_d) & mask_d);
    end

    // Outputs are set on entry to the state that owns them, so every
    // memory-side signal is a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            lane_q       <= 2'b00;
            wdata_q      <= 32'h0;
            address_q    <= 32'h0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            write_data_q <= 32'h0;
            rsp_valid_q  <= 1'b0;
            rsp_error_q  <= 1'b0;
            rsp_rdata_q  <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        lane_q     <= req_addr[1:0];
                        wdata_q    <= req_wdata;
                        address_q  <= {2'b00, req_addr[31:2]};
                        if (req_err_d) begin
                            state_q <= S_ERR;
                        end else if (!req_write) begin
                            state_q    <= S_LOAD;
                            mem_read_q <= 1'b1;
                        end else if (req_size == 2'b10) begin
                            state_q      <= S_STORE;
                            mem_write_q  <= 1'b1;
                            write_data_q <= req_wdata;
                        end else begin
                            state_q    <= S_RMW_RD;
                            mem_read_q <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    mem_read_q  <= 1'b0;
                    rsp_rdata_q <= load_ext_d;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_STORE: begin
                    mem_write_q <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RMW_RD: begin
                    // Old word is folded straight into the write-data register.
                    mem_read_q   <= 1'b0;
                    write_data_q <= merge_d;
                    mem_write_q  <= 1'b1;
                    state_q      <= S_RMW_WR;
                end
                S_RMW_WR: begin
                    mem_write_q <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_ERR: begin
                    rsp_error_q <= 1'b1;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    rsp_valid_q <= 1'b0;
                    rsp_error_q <= 1'b0;
                    rsp_rdata_q <= 32'h0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == S_IDLE) && !reset;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;
    assign address   = address_q;
    assign MemRead   = mem_read_q;
    assign MemWrite  = mem_write_q;
    assign writeData = write_data_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Bench for data_mem_access_unit: a transaction-level model predicts, per accepted
// request, which cycles carry MemRead/MemWrite, the written word, the response
// cycle and its data; a negedge process compares every cycle. Directed vectors
// also pin literal results.
module tb_data_mem_access_unit;

    localparam int DEPTH = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_error;
    logic [31:0] rsp_rdata;
    logic [31:0] address, writeData, readData;
    logic        MemRead, MemWrite;

    data_mem_access_unit #(.DEPTH(DEPTH), .RANGE_CHECK(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .address(address), .MemRead(MemRead), .writeData(writeData),
        .MemWrite(MemWrite), .readData(readData)
    );

    always #5 clk = ~clk;

    // Memory attached to the DUT, and the model's golden copy.
    logic [31:0] dmem [16] = '{0: 32'h11223344, 2: 32'h8899AABB, default: 32'h0};
    logic [31:0] gmem [16] = '{0: 32'h11223344, 2: 32'h8899AABB, default: 32'h0};

    assign readData = (address < 32'd16) ? dmem[address[3:0]] : 32'h0;
    always @(posedge clk) if (MemWrite && address < 32'd16) dmem[address[3:0]] <= writeData;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model state: at most one outstanding request.
    bit          chk_en = 0;
    bit          pend = 0;
    bit          p_err;
    int          p_rdcyc, p_wrcyc, p_rspcyc;
    logic [31:0] p_idx, p_wdata, p_rdata;
    int          acc_cnt = 0, rsp_cnt = 0, rd_cnt = 0, wr_cnt = 0;
    int          last_acc = 0, last_rsp = 0, last_lat = 0;
    logic [31:0] last_rdata = 0;
    logic        last_err = 0;

    task automatic model_accept();
        logic [31:0] idx, old, nw, v;
        int sh;
        idx = req_addr >> 2;
        p_err = (req_size == 2'd3) || (req_size == 2'd1 && req_addr % 2 != 0) ||
                (req_size == 2'd2 && req_addr % 4 != 0) || (idx >= DEPTH);
        old = (idx < 16) ? gmem[idx[3:0]] : 32'h0;
        nw = old; v = old;
        p_rdata = 0; p_rdcyc = -1; p_wrcyc = -1; p_rspcyc = cyc + 2;
        if (req_size == 2'd0) begin
            sh = 8 * int'(req_addr % 4);
            v  = (old >> sh) & 32'hFF;
            if (!req_unsigned && v >= 32'h80) v = v + 32'hFFFFFF00;
            nw[sh +: 8] = req_wdata[7:0];
        end else if (req_size == 2'd1) begin
            sh = 16 * int'((req_addr / 2) % 2);
            v  = (old >> sh) & 32'hFFFF;
            if (!req_unsigned && v >= 32'h8000) v = v + 32'hFFFF0000;
            nw[sh +: 16] = req_wdata[15:0];
        end else begin
            nw = req_wdata;
        end
        if (!p_err) begin
            if (!req_write) begin
                p_rdcyc = cyc + 1; p_rdata = v;
            end else if (req_size == 2'd2) begin
                p_wrcyc = cyc + 1;
            end else begin
                p_rdcyc = cyc + 1; p_wrcyc = cyc + 2; p_rspcyc = cyc + 3;
            end
        end
        p_idx = idx; p_wdata = nw; pend = 1;
        acc_cnt++; last_acc = cyc; rd_cnt = 0; wr_cnt = 0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            bit exp_ready, exp_rsp, exp_rd, exp_wr;
            exp_ready = !reset && !pend;
            exp_rsp   = pend && cyc == p_rspcyc;
            exp_rd    = pend && !p_err && cyc == p_rdcyc;
            exp_wr    = pend && !p_err && cyc == p_wrcyc;
            chk("req_ready", {31'h0, req_ready}, {31'h0, exp_ready});
            chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, exp_rsp});
            chk("MemRead",   {31'h0, MemRead},   {31'h0, exp_rd});
            chk("MemWrite",  {31'h0, MemWrite},  {31'h0, exp_wr});
            rd_cnt += int'(MemRead);
            wr_cnt += int'(MemWrite);
            if (exp_rd || exp_wr) chk("address", address, p_idx);
            if (exp_wr) begin
                chk("writeData", writeData, p_wdata);
                gmem[p_idx[3:0]] = p_wdata;
            end
            if (exp_rsp && rsp_valid) begin
                chk("rsp_rdata", rsp_rdata, p_rdata);
                chk("rsp_error", {31'h0, rsp_error}, {31'h0, p_err});
                if (!p_err) chk("mem_word", dmem[p_idx[3:0]], gmem[p_idx[3:0]]);
                last_rdata = rsp_rdata; last_err = rsp_error;
                last_rsp = cyc; last_lat = cyc - last_acc; rsp_cnt++;
            end
            if (exp_rsp || reset) pend = 0;
            if (exp_ready && req_valid) model_accept();
        end
    end

    // Drivers run at posedge+2.
    task automatic send(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd);
        int a0, b;
        a0 = acc_cnt; b = 0;
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        while (acc_cnt == a0 && b < 20) begin @(posedge clk); #2; b++; end
        if (b >= 20) chk("accept_timeout", 32'(b), 32'd0);
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while (pend && b < 20) begin @(posedge clk); #2; b++; end
        if (b >= 20) chk("rsp_timeout", 32'(b), 32'd0);
        @(posedge clk); #2;
    endtask

    task automatic op(input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] wd);
        send(w, sz, u, a, wd);
        req_valid = 1'b0;
        wait_idle();
    endtask

    task automatic expect_rsp(input string name, input logic [31:0] rd, input logic er, input int lat);
        chk({name, "_rdata"}, last_rdata, rd);
        chk({name, "_err"}, {31'h0, last_err}, {31'h0, er});
        chk({name, "_lat"}, 32'(last_lat), 32'(lat));
    endtask

    initial begin
        int r0;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        @(posedge clk); #2;
        chk_en = 1;
        @(negedge clk);
        chk("reset_address", address, 32'h0);
        chk("reset_wdata", writeData, 32'h0);
        chk("reset_rdata", rsp_rdata, 32'h0);
        @(posedge clk); #2;
        reset = 1'b0;

        // Loads from word 2 = 0x8899AABB.
        op(0, 2'd0, 0, 32'h0B, 0); expect_rsp("lb_s", 32'hFFFFFF88, 0, 2);
        chk("lb_s_reads", 32'(rd_cnt), 32'd1);
        op(0, 2'd0, 1, 32'h0B, 0); expect_rsp("lb_u", 32'h00000088, 0, 2);
        op(0, 2'd1, 0, 32'h08, 0); expect_rsp("lh_s", 32'hFFFFAABB, 0, 2);
        op(0, 2'd2, 0, 32'h08, 0); expect_rsp("lw",   32'h8899AABB, 0, 2);

        // Byte store via read-modify-write, then reload.
        op(1, 2'd0, 0, 32'h09, 32'h12345677); expect_rsp("sb", 32'h0, 0, 3);
        chk("sb_mem", dmem[2], 32'h889977BB);
        chk("sb_writes", 32'(wr_cnt), 32'd1);
        op(0, 2'd2, 0, 32'h08, 0); expect_rsp("lw2", 32'h889977BB, 0, 2);

        // Upper halfword store, then lane reads.
        op(1, 2'd1, 0, 32'h0A, 32'hCAFE5A5A); expect_rsp("sh", 32'h0, 0, 3);
        chk("sh_mem", dmem[2], 32'h5A5A77BB);
        op(0, 2'd1, 1, 32'h0A, 0); expect_rsp("lhu_hi", 32'h00005A5A, 0, 2);
        op(0, 2'd0, 0, 32'h09, 0); expect_rsp("lb_s1",  32'h00000077, 0, 2);

        // Error cases: no memory enables at all.
        op(0, 2'd1, 0, 32'h05, 0); expect_rsp("e_mis", 32'h0, 1, 2);
        chk("e_mis_en", 32'(rd_cnt + wr_cnt), 32'd0);
        op(0, 2'd2, 0, 32'h28, 0); expect_rsp("e_oor", 32'h0, 1, 2);
        chk("e_oor_en", 32'(rd_cnt + wr_cnt), 32'd0);
        op(1, 2'd3, 0, 32'h04, 32'h1); expect_rsp("e_size", 32'h0, 1, 2);
        chk("e_size_en", 32'(rd_cnt + wr_cnt), 32'd0);

        // Back-to-back: store then load held valid.
        send(1, 2'd2, 0, 32'h04, 32'hDEADBEEF);
        send(0, 2'd2, 0, 32'h04, 0);
        chk("b2b_accept_gap", 32'(last_acc - last_rsp), 32'd1);
        req_valid = 1'b0;
        wait_idle();
        expect_rsp("b2b_lw", 32'hDEADBEEF, 0, 2);

        // Reset during RMW_RD of a byte store to word 0.
        r0 = rsp_cnt;
        send(1, 2'd0, 0, 32'h00, 32'h000000FF);
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'h0, req_ready}, 32'd1);
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("rst_no_write", 32'(wr_cnt), 32'd0);
        chk("rst_no_rsp", 32'(rsp_cnt - r0), 32'd0);
        chk("rst_mem0", dmem[0], 32'h11223344);
        op(0, 2'd2, 0, 32'h00, 0); expect_rsp("rst_lw0", 32'h11223344, 0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/data_mem_access_unit.md
Name: data_mem_access_unit

Overview:
- Initiator side of the data-memory port: it drives `address`/`MemRead`/`writeData`/`MemWrite` into the word-addressed data memory and receives `readData`.
- It takes byte-addressed load/store requests from the core over a valid/ready handshake.
- It supports byte, halfword and word accesses, little-endian. Loads are sign- or zero-extended; sub-word stores use a two-cycle read-modify-write.
- It flags misaligned, out-of-range and illegal-size requests without touching memory.

Parameters:
- DEPTH, 10, number of 32-bit words in the attached data memory; word index >= DEPTH is out of range.
- RANGE_CHECK, 1, 1 = report out-of-range requests as errors; 0 = pass the word index through unchecked.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit idle and able to accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_error  output  1  valid with rsp_valid; misaligned, out-of-range or illegal size.
- address  output  32  word index to memory = {2'b00, addr[31:2]}.
- MemRead  output  1  memory read enable.
- writeData  output  32  word written to memory.
- MemWrite  output  1  memory write enable.
- readData  input  32  memory read data, combinational from `address`.

Behaviour:
- Decided interface: one clock (`clk`); reset (`reset`) is synchronous and active-high.
- Reset values: state IDLE; `req_ready`=0 while `reset` is high, 1 in the first cycle after; all other outputs 0; captured request registers cleared.
- Output timing: all memory-side outputs come only from registered state and captured fields. There is no combinational path from req_* to `address`/`MemRead`/`MemWrite`/`writeData`.
- States and transitions:
  - IDLE: `req_ready`=1. On `req_valid`, capture all req_* fields and go to one of:
    - ERR, if size is illegal, the access is misaligned, or it is out of range (RANGE_CHECK=1). Misaligned = halfword with addr[0]=1, or word with addr[1:0]!=0.
    - LOAD, for a load.
    - STORE, for a word store.
    - RMW_RD, for a byte or halfword store.
  - LOAD: `MemRead`=1. Extract the lane from `readData` and register the extended result; go to RESP.
  - STORE: `MemWrite`=1, `writeData`=captured wdata; go to RESP.
  - RMW_RD: `MemRead`=1. Register `readData` as the old word; go to RMW_WR.
  - RMW_WR: `MemWrite`=1. `writeData` = old word with the target lane replaced by wdata[7:0] (byte) or wdata[15:0] (halfword); go to RESP.
  - ERR: no memory enables asserted; go to RESP with error latched.
  - RESP: `rsp_valid`=1 for exactly one cycle; `req_ready`=0; go to IDLE.
- Lane selection:
  - Byte lane = addr[1:0]; lane 0 = bits [7:0].
  - Halfword lane = addr[1]; lane 0 = bits [15:0].
- Extension: sign extension replicates the lane MSB; unsigned zero-fills. Word loads are unmodified.
- Latency from the accept cycle T: rsp_valid at T+2 for loads, word stores and errors; T+3 for sub-word stores.
- Back-to-back: a new request is accepted in the IDLE cycle after RESP. Throughput is at most one request per 3 cycles (4 for sub-word stores).
- Enables: `MemRead` and `MemWrite` are never high in the same cycle, and are each high for exactly one cycle per access. `address` stays stable for the whole access, including both RMW cycles.
- Mid-operation reset: reset sampled in any state returns to IDLE next edge with no rsp_valid. Reset in RMW_RD means the write never occurs. Reset in STORE/RMW_WR does not suppress that cycle's write, since memory writes the same edge.
- `req_valid` outside IDLE is ignored; `req_ready`=0 there.

Test Plan:
- Preload word 2=0x8899AABB. Load byte, signed, addr 0x0B -> `address`=2, `MemRead` 1 cycle, rsp at T+2, rdata=0xFFFFFF88, error=0. Same with unsigned -> 0x00000088.
- Load halfword, signed, addr 0x08 -> rdata=0xFFFFAABB. Load word, addr 0x08 -> 0x8899AABB.
- Store byte, wdata 0x12345677, addr 0x09 -> RMW_RD then RMW_WR with writeData=0x889977BB; rsp at T+3; reload word 2 = 0x889977BB.
- Error cases, each -> rsp_error=1 at T+2, rdata=0, `MemRead`/`MemWrite` never asserted:
  - halfword at addr 0x05 (misaligned);
  - word at addr 0x28 (index 10 >= DEPTH);
  - req_size=11.
- Back-to-back: word store 0xDEADBEEF to 0x04, then load word 0x04 held valid -> second accept exactly one cycle after first rsp; load returns 0xDEADBEEF.
- Reset in RMW_RD of byte store to 0x00 (word 0 = 0x11223344) -> no `MemWrite`, no rsp_valid, word 0 unchanged, `req_ready`=1 the cycle after reset deasserts.
